// File: rtl/iopmp_pkg.sv
// Shared iopmp types: access kind presented to the checker alongside address and source id.
package iopmp_pkg;

    typedef enum logic [1:0] {
        ACCESS_READ  = 2'd0,
        ACCESS_WRITE = 2'd1,
        ACCESS_EXEC  = 2'd2
    } iopmp_access_t;

endpackage

// File: rtl/iopmp_txn_gate.sv
// Single-outstanding DMA enforcement gate: checks each request against the iopmp verdict,
// forwards allowed transactions and answers denied ones locally with SLVERR.
module iopmp_txn_gate
    import iopmp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 34,
    parameter int unsigned ID_WIDTH   = 10,
    parameter int unsigned SID_WIDTH  = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,

    input  logic                                         s_req_valid_i,
    output logic                                         s_req_ready_o,
    input  logic [1+SID_WIDTH+8+ID_WIDTH+ADDR_WIDTH-1:0] s_req_i,

    output logic                                         m_req_valid_o,
    input  logic                                         m_req_ready_i,
    output logic [1+8+ID_WIDTH+ADDR_WIDTH-1:0]           m_req_o,

    input  logic                                         s_w_valid_i,
    input  logic                                         s_w_last_i,
    output logic                                         s_w_ready_o,
    output logic                                         m_w_valid_o,
    input  logic                                         m_w_ready_i,

    output logic [ADDR_WIDTH-1:0]                        chk_addr_o,
    output logic [SID_WIDTH-1:0]                         chk_sid_o,
    output iopmp_access_t                                chk_access_o,
    input  logic                                         chk_allow_i,

    input  logic                                         m_rsp_valid_i,
    input  logic [2:0]                                   m_rsp_i,
    output logic                                         m_rsp_ready_o,
    output logic                                         s_rsp_valid_o,
    output logic [1+ID_WIDTH+3-1:0]                      s_rsp_o,
    input  logic                                         s_rsp_ready_i,

    output logic                                         deny_o,
    output logic [CNT_WIDTH-1:0]                         deny_cnt_o
);

    localparam int unsigned REQ_W   = 1 + SID_WIDTH + 8 + ID_WIDTH + ADDR_WIDTH;
    localparam int unsigned ID_LSB  = ADDR_WIDTH;
    localparam int unsigned LEN_LSB = ID_LSB + ID_WIDTH;
    localparam int unsigned SID_LSB = LEN_LSB + 8;
    localparam int unsigned WE_BIT  = SID_LSB + SID_WIDTH;
    localparam int unsigned BEAT_W  = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FWD_REQ,
        ST_PASS_W,
        ST_WAIT_RSP,
        ST_DRAIN_W,
        ST_ERR_RSP
    } state_e;

    state_e                state_q, state_d;
    logic [REQ_W-1:0]      req_q, req_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  deny_q, deny_d;
    logic [CNT_WIDTH-1:0]  deny_cnt_q, deny_cnt_d;

    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [ID_WIDTH-1:0]   cap_id;
    logic [7:0]            cap_len;
    logic [SID_WIDTH-1:0]  cap_sid;
    logic                  cap_we;
    logic                  err_last;

    // Captured request fields.
    assign cap_addr = req_q[ADDR_WIDTH-1:0];
    assign cap_id   = req_q[LEN_LSB-1:ID_LSB];
    assign cap_len  = req_q[SID_LSB-1:LEN_LSB];
    assign cap_sid  = req_q[WE_BIT-1:SID_LSB];
    assign cap_we   = req_q[WE_BIT];

    // Injected writes are a single B beat; injected reads run len+1 beats.
    assign err_last = cap_we || (beat_q == {1'b0, cap_len});

    assign chk_addr_o   = cap_addr;
    assign chk_sid_o    = cap_sid;
    assign chk_access_o = cap_we ? ACCESS_WRITE : ACCESS_READ;
    assign m_req_o      = {cap_we, cap_len, cap_id, cap_addr};
    assign deny_o       = deny_q;
    assign deny_cnt_o   = deny_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            beat_q     <= '0;
            deny_q     <= 1'b0;
            deny_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            beat_q     <= beat_d;
            deny_q     <= deny_d;
            deny_cnt_q <= deny_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        beat_d        = beat_q;
        deny_d        = 1'b0;
        deny_cnt_d    = deny_cnt_q;
        s_req_ready_o = 1'b0;
        m_req_valid_o = 1'b0;
        s_w_ready_o   = 1'b0;
        m_w_valid_o   = 1'b0;
        m_rsp_ready_o = 1'b0;
        s_rsp_valid_o = 1'b0;
        s_rsp_o       = '0;

        case (state_q)
            ST_IDLE: begin
                s_req_ready_o = 1'b1;
                if (s_req_valid_i) begin
                    req_d   = s_req_i;
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                beat_d = '0;
                if (chk_allow_i) begin
                    state_d = ST_FWD_REQ;
                end else begin
                    deny_d = 1'b1;
                    if (deny_cnt_q != {CNT_WIDTH{1'b1}}) begin
                        deny_cnt_d = deny_cnt_q + CNT_WIDTH'(1);
                    end
                    state_d = cap_we ? ST_DRAIN_W : ST_ERR_RSP;
                end
            end

            ST_FWD_REQ: begin
                m_req_valid_o = 1'b1;
                if (m_req_ready_i) begin
                    state_d = cap_we ? ST_PASS_W : ST_WAIT_RSP;
                end
            end

            ST_PASS_W: begin
                m_w_valid_o = s_w_valid_i;
                s_w_ready_o = m_w_ready_i;
                if (s_w_valid_i && m_w_ready_i && s_w_last_i) begin
                    state_d = ST_WAIT_RSP;
                end
            end

            ST_WAIT_RSP: begin
                s_rsp_valid_o = m_rsp_valid_i;
                m_rsp_ready_o = s_rsp_ready_i;
                s_rsp_o       = {1'b0, cap_id, m_rsp_i};
                if (m_rsp_valid_i && s_rsp_ready_i && m_rsp_i[0]) begin
                    state_d = ST_IDLE;
                end
            end

            // Denied write: swallow the data so the master's W channel completes.
            ST_DRAIN_W: begin
                s_w_ready_o = 1'b1;
                if (s_w_valid_i && s_w_last_i) begin
                    state_d = ST_ERR_RSP;
                end
            end

            ST_ERR_RSP: begin
                s_rsp_valid_o = 1'b1;
                s_rsp_o       = {1'b1, cap_id, 2'b10, err_last};
                if (s_rsp_ready_i) begin
                    if (err_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iopmp_txn_gate.sv
// Randomized bench for iopmp_txn_gate: a checker policy plus a transaction-level model of
// the expected forward / drain / injected-error behaviour.
module tb_iopmp_txn_gate;
    import iopmp_pkg::*;

    localparam int unsigned AW      = 34;
    localparam int unsigned IW      = 10;
    localparam int unsigned SW      = 1;
    localparam int unsigned CW      = 3;
    localparam int unsigned REQ_W   = 1 + SW + 8 + IW + AW;
    localparam int unsigned MREQ_W  = 1 + 8 + IW + AW;
    localparam int unsigned RSP_W   = 1 + IW + 3;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              s_req_valid_i, s_req_ready_o;
    logic [REQ_W-1:0]  s_req_i;
    logic              m_req_valid_o, m_req_ready_i;
    logic [MREQ_W-1:0] m_req_o;
    logic              s_w_valid_i, s_w_last_i, s_w_ready_o, m_w_valid_o, m_w_ready_i;
    logic [AW-1:0]     chk_addr_o;
    logic [SW-1:0]     chk_sid_o;
    iopmp_access_t     chk_access_o;
    logic              chk_allow_i;
    logic              m_rsp_valid_i, m_rsp_ready_o, s_rsp_valid_o, s_rsp_ready_i;
    logic [2:0]        m_rsp_i;
    logic [RSP_W-1:0]  s_rsp_o;
    logic              deny_o;
    logic [CW-1:0]     deny_cnt_o;

    int n_vec  = 0;
    int n_err  = 0;
    int deny_m = 0;

    always #5 clk_i = ~clk_i;

    iopmp_txn_gate #(
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .SID_WIDTH  (SW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .s_req_valid_i (s_req_valid_i),
        .s_req_ready_o (s_req_ready_o),
        .s_req_i       (s_req_i),
        .m_req_valid_o (m_req_valid_o),
        .m_req_ready_i (m_req_ready_i),
        .m_req_o       (m_req_o),
        .s_w_valid_i   (s_w_valid_i),
        .s_w_last_i    (s_w_last_i),
        .s_w_ready_o   (s_w_ready_o),
        .m_w_valid_o   (m_w_valid_o),
        .m_w_ready_i   (m_w_ready_i),
        .chk_addr_o    (chk_addr_o),
        .chk_sid_o     (chk_sid_o),
        .chk_access_o  (chk_access_o),
        .chk_allow_i   (chk_allow_i),
        .m_rsp_valid_i (m_rsp_valid_i),
        .m_rsp_i       (m_rsp_i),
        .m_rsp_ready_o (m_rsp_ready_o),
        .s_rsp_valid_o (s_rsp_valid_o),
        .s_rsp_o       (s_rsp_o),
        .s_rsp_ready_i (s_rsp_ready_i),
        .deny_o        (deny_o),
        .deny_cnt_o    (deny_cnt_o)
    );

    // Checker policy: addr[31] is forbidden; sid 0 may not write where addr[30] is set.
    function automatic logic policy(input logic [AW-1:0] a, input logic [SW-1:0] s,
                                    input iopmp_access_t acc);
        return !a[31] && !(acc == ACCESS_WRITE && s == '0 && a[30]);
    endfunction

    assign chk_allow_i = policy(chk_addr_o, chk_sid_o, chk_access_o);

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_idle();
        s_req_valid_i = 1'b0;
        s_w_valid_i   = 1'b0;
        s_w_last_i    = 1'b0;
        m_w_ready_i   = 1'b0;
        m_req_ready_i = 1'b0;
        m_rsp_valid_i = 1'b0;
        m_rsp_i       = 3'd0;
        s_rsp_ready_i = 1'b0;
    endtask

    function automatic logic ready_gen(input int k, input int stall, input bit rnd);
        return (k >= stall) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
    endfunction

    task automatic check_deny(input logic allow, inout logic first);
        check_val("deny_pulse", 64'(deny_o), 64'(first && !allow));
        if (first && !allow) check_val("deny_cnt", 64'(deny_cnt_o), 64'(deny_m));
        first = 1'b0;
    endtask

    task automatic run_txn(input logic we, input logic [SW-1:0] sid, input logic [7:0] len,
                           input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input int req_stall, input int rsp_stall, input bit rnd);
        logic              allow, first, hs;
        int                k, b, nb;
        logic [MREQ_W-1:0] exp_mreq;
        logic [2:0]        rsp_beat;
        allow    = policy(addr, sid, we ? ACCESS_WRITE : ACCESS_READ);
        exp_mreq = {we, len, id, addr};
        if (!allow && deny_m < CNT_MAX) deny_m++;

        s_req_valid_i = 1'b1;
        s_req_i       = {we, sid, len, id, addr};
        #1;
        check_val("req_ready_idle", 64'(s_req_ready_o), 64'(1));

        // Check cycle: checker sees the captured request; nothing else moves.
        tick();
        drive_idle();
        s_req_valid_i = 1'b1;
        s_req_i       = REQ_W'({$urandom, $urandom});
        s_w_valid_i   = 1'b1;
        #1;
        check_val("chk_addr", 64'(chk_addr_o), 64'(addr));
        check_val("chk_sid", 64'(chk_sid_o), 64'(sid));
        check_val("chk_access", 64'(chk_access_o), 64'(we ? ACCESS_WRITE : ACCESS_READ));
        check_val("chk_req_ready", 64'(s_req_ready_o), 64'(0));
        check_val("chk_m_req_valid", 64'(m_req_valid_o), 64'(0));
        check_val("chk_w_ready", 64'(s_w_ready_o), 64'(0));
        first = 1'b1;

        if (allow) begin
            k  = 0;
            hs = 1'b0;
            while (!hs && k < 200) begin
                tick();
                drive_idle();
                s_req_valid_i = 1'b1;
                m_req_ready_i = ready_gen(k, req_stall, rnd);
                s_w_valid_i   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                #1;
                check_deny(allow, first);
                check_val("m_req_valid", 64'(m_req_valid_o), 64'(1));
                check_val("m_req_data", 64'(m_req_o), 64'(exp_mreq));
                check_val("fwd_req_ready", 64'(s_req_ready_o), 64'(0));
                check_val("fwd_w_ready", 64'(s_w_ready_o), 64'(0));
                hs = m_req_ready_i;
                k++;
            end
            check_val("req_handshake", 64'(hs), 64'(1));
        end

        if (we) begin
            nb = int'(len) + 1;
            b  = 0;
            k  = 0;
            while (b < nb && k < 4000) begin
                tick();
                drive_idle();
                s_req_valid_i = 1'b1;
                s_w_valid_i   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                s_w_last_i    = (b == nb - 1);
                m_w_ready_i   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                m_rsp_valid_i = 1'($urandom_range(0, 1));
                s_rsp_ready_i = 1'b1;
                #1;
                check_deny(allow, first);
                if (allow) begin
                    check_val("w_valid_pass", 64'(m_w_valid_o), 64'(s_w_valid_i));
                    check_val("w_ready_pass", 64'(s_w_ready_o), 64'(m_w_ready_i));
                    hs = s_w_valid_i && m_w_ready_i;
                end else begin
                    check_val("drain_w_ready", 64'(s_w_ready_o), 64'(1));
                    check_val("drain_m_w_valid", 64'(m_w_valid_o), 64'(0));
                    hs = s_w_valid_i;
                end
                check_val("w_rsp_ready", 64'(m_rsp_ready_o), 64'(0));
                check_val("w_rsp_valid", 64'(s_rsp_valid_o), 64'(0));
                check_val("w_req_ready", 64'(s_req_ready_o), 64'(0));
                if (hs) b++;
                k++;
            end
            check_val("w_beats", 64'(b), 64'(nb));
        end

        nb       = we ? 1 : int'(len) + 1;
        b        = 0;
        k        = 0;
        rsp_beat = {2'($urandom_range(0, 3)), 1'(nb == 1)};
        while (b < nb && k < 4000) begin
            tick();
            drive_idle();
            s_req_valid_i = 1'b1;
            s_w_valid_i   = 1'($urandom_range(0, 1));
            s_rsp_ready_i = ready_gen(k, rsp_stall, rnd);
            if (allow) begin
                m_rsp_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                m_rsp_i       = rsp_beat;
            end else begin
                m_rsp_valid_i = 1'($urandom_range(0, 1));
                m_rsp_i       = 3'($urandom_range(0, 7));
            end
            #1;
            check_deny(allow, first);
            check_val("rsp_w_ready", 64'(s_w_ready_o), 64'(0));
            check_val("rsp_req_ready", 64'(s_req_ready_o), 64'(0));
            if (allow) begin
                check_val("rsp_valid_pass", 64'(s_rsp_valid_o), 64'(m_rsp_valid_i));
                check_val("rsp_ready_pass", 64'(m_rsp_ready_o), 64'(s_rsp_ready_i));
                if (m_rsp_valid_i) check_val("rsp_data", 64'(s_rsp_o), 64'({1'b0, id, rsp_beat}));
                hs = m_rsp_valid_i && s_rsp_ready_i;
            end else begin
                check_val("err_valid", 64'(s_rsp_valid_o), 64'(1));
                check_val("err_m_rsp_ready", 64'(m_rsp_ready_o), 64'(0));
                check_val("err_data", 64'(s_rsp_o), 64'({1'b1, id, 2'b10, 1'(b == nb - 1)}));
                hs = s_rsp_ready_i;
            end
            if (hs) begin
                b++;
                rsp_beat = {2'($urandom_range(0, 3)), 1'(b == nb - 1)};
            end
            k++;
        end
        check_val("rsp_beats", 64'(b), 64'(nb));

        tick();
        drive_idle();
        #1;
        check_val("back_to_idle", 64'(s_req_ready_o), 64'(1));
        check_val("idle_rsp_valid", 64'(s_rsp_valid_o), 64'(0));
    endtask

    initial begin
        rst_i   = 1'b1;
        s_req_i = '0;
        drive_idle();
        repeat (3) tick();
        check_val("rst_req_ready", 64'(s_req_ready_o), 64'(1));
        check_val("rst_m_req_valid", 64'(m_req_valid_o), 64'(0));
        check_val("rst_rsp_valid", 64'(s_rsp_valid_o), 64'(0));
        check_val("rst_deny_cnt", 64'(deny_cnt_o), 64'(0));
        check_val("rst_chk_addr", 64'(chk_addr_o), 64'(0));
        check_val("rst_chk_access", 64'(chk_access_o), 64'(ACCESS_READ));
        rst_i = 1'b0;

        // Directed scenarios.
        run_txn(1'b0, 1'b1, 8'd3, 10'h2A, 34'h1000, 0, 0, 1'b0);
        run_txn(1'b1, 1'b1, 8'd1, 10'h005, 34'h8000_0000, 0, 0, 1'b0);
        run_txn(1'b0, 1'b0, 8'd0, 10'h003, 34'h8000_0040, 0, 0, 1'b1);
        run_txn(1'b0, 1'b1, 8'd255, 10'h0F1, 34'h8000_0080, 0, 0, 1'b1);
        run_txn(1'b0, 1'b1, 8'd2, 10'h077, 34'h4000, 5, 3, 1'b0);
        run_txn(1'b1, 1'b1, 8'd1, 10'h078, 34'h5000, 5, 3, 1'b0);
        run_txn(1'b1, 1'b0, 8'd0, 10'h009, 34'h4000_0000, 0, 0, 1'b1);
        run_txn(1'b0, 1'b0, 8'd0, 10'h009, 34'h4000_0000, 0, 0, 1'b1);

        // Random mix of reads/writes across allowed and denied regions.
        for (int i = 0; i < 60; i++) begin
            logic we_r;
            we_r = 1'($urandom_range(0, 1));
            run_txn(we_r, 1'($urandom_range(0, 1)),
                    we_r ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 15)),
                    10'($urandom), {2'($urandom_range(0, 3)), 32'($urandom)},
                    $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
        end

        // Push the counter past its ceiling.
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            run_txn(1'b0, 1'b0, 8'd0, 10'($urandom), 34'h8000_0000, 0, 0, 1'b1);
        end
        check_val("deny_saturated", 64'(deny_cnt_o), 64'(CNT_MAX));

        // Reset in the middle of a forwarded write after one of four beats.
        s_req_valid_i = 1'b1;
        s_req_i       = {1'b1, 1'b1, 8'd3, 10'h011, 34'h2000};
        #1;
        tick();
        drive_idle();
        #1;
        tick();
        drive_idle();
        m_req_ready_i = 1'b1;
        #1;
        check_val("mid_fwd_valid", 64'(m_req_valid_o), 64'(1));
        tick();
        drive_idle();
        s_w_valid_i = 1'b1;
        m_w_ready_i = 1'b1;
        #1;
        check_val("mid_pass_w_ready", 64'(s_w_ready_o), 64'(1));
        tick();
        rst_i = 1'b1;
        #1;
        tick();
        rst_i         = 1'b0;
        s_w_valid_i   = 1'b1;
        m_w_ready_i   = 1'b1;
        m_rsp_valid_i = 1'b1;
        s_rsp_ready_i = 1'b1;
        #1;
        deny_m = 0;
        check_val("mrst_m_req_valid", 64'(m_req_valid_o), 64'(0));
        check_val("mrst_m_w_valid", 64'(m_w_valid_o), 64'(0));
        check_val("mrst_s_w_ready", 64'(s_w_ready_o), 64'(0));
        check_val("mrst_s_rsp_valid", 64'(s_rsp_valid_o), 64'(0));
        check_val("mrst_m_rsp_ready", 64'(m_rsp_ready_o), 64'(0));
        check_val("mrst_deny", 64'(deny_o), 64'(0));
        check_val("mrst_deny_cnt", 64'(deny_cnt_o), 64'(deny_m));
        check_val("mrst_req_ready", 64'(s_req_ready_o), 64'(1));
        check_val("mrst_chk_addr", 64'(chk_addr_o), 64'(0));
        drive_idle();

        // Gate must still work normally after the abandoned transaction.
        run_txn(1'b0, 1'b1, 8'd1, 10'h0AB, 34'h3000, 0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
